// File: rtl/mau_pkg.sv
// Shared encodings for the data-memory access unit: access sizes, FSM states
// and the alignment rule used to reject requests before they touch memory.
package mau_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_READ,
    STORE,
    RESP
  } mau_state_t;

  // True when the size is illegal or the address is not naturally aligned.
  function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_shifter.sv
// Little-endian lane logic: extracts and extends a loaded byte/half/word, and
// merges store data into an existing word leaving unselected bytes untouched.
module mem_lane_shifter
  import mau_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] load_data,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] merged_word
);

  logic [15:0] shifted;
  logic [31:0] wr_rep;

  assign shifted = 16'(rd_word >> {lane, 3'b000});

  always_comb begin
    load_data = '0;
    case (size)
      SZ_BYTE: load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      SZ_WORD: load_data = rd_word;
      default: load_data = '0;
    endcase
  end

  // Replicate the store data across every lane so each byte slot can simply
  // pick either the replicated new byte or the old byte.
  always_comb begin
    wr_rep = new_data;
    case (size)
      SZ_BYTE: wr_rep = {4{new_data[7:0]}};
      SZ_HALF: wr_rep = {2{new_data[15:0]}};
      default: wr_rep = new_data;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic byte_en;
      assign byte_en = (size == SZ_BYTE) ? (lane == 2'(gi)) :
                       (size == SZ_HALF) ? (lane[1] == 1'(gi / 2)) : 1'b1;
      assign merged_word[8*gi +: 8] = byte_en ? wr_rep[8*gi +: 8] : old_word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-wide data memory with combinational read and
// synchronous write; sub-word stores are performed as read-modify-write.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  mau_state_t state_reg, state_next;

  logic              we_reg;
  logic [1:0]        size_reg;
  logic              signed_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       buf_reg;
  logic [31:0]       resp_rdata_reg;
  logic              resp_err_reg;

  logic        accept;
  logic        req_err;
  logic        store_cycle;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign accept  = req_valid && req_ready;
  assign req_err = req_is_bad(req_size, req_addr[1:0]);

  mem_lane_shifter u_lane_shifter (
    .rd_word    (mem_rdata),
    .lane       (addr_reg[1:0]),
    .size       (size_reg),
    .sign_ext   (signed_reg),
    .load_data  (load_data),
    .old_word   (mem_rdata),
    .new_data   (wdata_reg),
    .merged_word(merged_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    req_ready   = 1'b0;
    store_cycle = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err) begin
            state_next = RESP;
          end else if (!req_we) begin
            state_next = LOAD;
          end else if (req_size == SZ_WORD) begin
            state_next = STORE;
          end else begin
            state_next = RMW_READ;
          end
        end
      end
      LOAD:     state_next = RESP;
      RMW_READ: state_next = STORE;
      STORE: begin
        store_cycle = 1'b1;
        state_next  = RESP;
      end
      RESP:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Request latch, RMW merge buffer and response registers. The response
  // registers only change on the way into RESP so they hold between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_reg         <= 1'b0;
      size_reg       <= SZ_BYTE;
      signed_reg     <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      buf_reg        <= '0;
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        we_reg     <= req_we;
        size_reg   <= req_size;
        signed_reg <= req_signed;
        addr_reg   <= req_addr;
        wdata_reg  <= req_wdata;
      end
      if (state_reg == RMW_READ) begin
        buf_reg <= merged_word;
      end
      case (state_reg)
        IDLE: begin
          if (accept && req_err) begin
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b1;
          end
        end
        LOAD: begin
          resp_rdata_reg <= load_data;
          resp_err_reg   <= 1'b0;
        end
        STORE: begin
          resp_rdata_reg <= '0;
          resp_err_reg   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // The write strobe is masked by reset so an interrupted store never lands.
  assign mem_we     = store_cycle && !reset && we_reg;
  assign mem_addr   = {addr_reg[ADDR_W-1:2], 2'b00};
  assign mem_wdata  = (size_reg == SZ_WORD) ? wdata_reg : buf_reg;
  assign resp_valid = (state_reg == RESP);
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: table of requests driven through a
// scoreboard, plus hand sequences for back-to-back handshake and reset abort.
module tb_mem_access_unit;
  import mau_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_signed(req_signed),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on the rising edge.
  logic [31:0] tb_mem [0:63];
  logic        mem_init = 1'b1;
  assign mem_rdata = tb_mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= 32'h0;
      tb_mem[12] <= 32'h80FF7F01;
    end else if (mem_we) begin
      tb_mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          lat;
    logic        exp_wr;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    vec_t v;
    int   accept;
  } sb_t;

  sb_t  sbq[$];
  vec_t vecs[$];
  logic wr_seen = 1'b0;
  logic mon_en = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cycle_cnt);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input int lat, input logic exp_wr, input logic [31:0] exp_wdata);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.lat = lat;
    v.exp_wr = exp_wr; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  // Monitor: checks busy-period ready, every memory write and every response.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sbq.size() > 0 && cycle_cnt >= sbq[0].accept)
        chk("ready_while_busy", {31'b0, req_ready}, 32'd0);
      if (mem_we) begin
        if (sbq.size() == 0) begin
          chk("unexpected_mem_we", {31'b0, mem_we}, 32'd0);
        end else begin
          chk("we_allowed", {31'b0, mem_we}, {31'b0, sbq[0].v.exp_wr});
          chk("we_cycle", cycle_cnt - sbq[0].accept + 1, sbq[0].v.lat - 1);
          chk("we_addr", mem_addr, {sbq[0].v.addr[31:2], 2'b00});
          chk("we_data", mem_wdata, sbq[0].v.exp_wdata);
          wr_seen = 1'b1;
        end
      end
      if (resp_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_resp", {31'b0, resp_valid}, 32'd0);
        end else begin
          chk("resp_latency", cycle_cnt - sbq[0].accept + 1, sbq[0].v.lat);
          chk("resp_rdata", resp_rdata, sbq[0].v.exp_rdata);
          chk("resp_err", {31'b0, resp_err}, {31'b0, sbq[0].v.exp_err});
          chk("write_count", {31'b0, wr_seen}, {31'b0, sbq[0].v.exp_wr});
          $display("[TB] %s size=%0d addr=%h wdata=%h -> rdata=%h err=%0d",
                   sbq[0].v.we ? "store" : "load ", sbq[0].v.size, sbq[0].v.addr,
                   sbq[0].v.wdata, resp_rdata, resp_err);
          void'(sbq.pop_front());
          wr_seen = 1'b0;
        end
      end
    end
  end

  task automatic do_req(input vec_t v, input bit keep);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("ready_timeout", {31'b0, req_ready}, 32'd1);
      return;
    end
    req_valid  = 1'b1;
    req_we     = v.we;
    req_size   = v.size;
    req_signed = v.sgn;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    sbq.push_back('{v: v, accept: cycle_cnt + 1});
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
    // Scramble the request after acceptance; the latched copy must win.
    req_we     = 1'($urandom);
    req_size   = 2'($urandom_range(0, 3));
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() > 0) begin
      chk("drain_timeout", sbq.size(), 32'd0);
      sbq.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // we, size, sgn, addr, wdata, exp_rdata, exp_err, lat, exp_wr, exp_wdata
    vecs.push_back(mk(1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2, 1, 32'hDEADBEEF));
    vecs.push_back(mk(0, SZ_WORD, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 0, 32'h0));
    vecs.push_back(mk(1, SZ_BYTE, 0, 32'h11, 32'hABCDEF12, 32'h0,        0, 3, 1, 32'hDEAD12EF));
    vecs.push_back(mk(0, SZ_WORD, 0, 32'h10, 32'h0,        32'hDEAD12EF, 0, 2, 0, 32'h0));
    vecs.push_back(mk(0, SZ_BYTE, 1, 32'h33, 32'h0,        32'hFFFFFF80, 0, 2, 0, 32'h0));
    vecs.push_back(mk(0, SZ_BYTE, 0, 32'h33, 32'h0,        32'h00000080, 0, 2, 0, 32'h0));
    vecs.push_back(mk(0, SZ_BYTE, 1, 32'h32, 32'h0,        32'hFFFFFFFF, 0, 2, 0, 32'h0));
    vecs.push_back(mk(0, SZ_BYTE, 0, 32'h32, 32'h0,        32'h000000FF, 0, 2, 0, 32'h0));
    vecs.push_back(mk(0, SZ_BYTE, 1, 32'h31, 32'h0,        32'h0000007F, 0, 2, 0, 32'h0));
    vecs.push_back(mk(0, SZ_HALF, 1, 32'h30, 32'h0,        32'h00007F01, 0, 2, 0, 32'h0));
    vecs.push_back(mk(0, SZ_HALF, 1, 32'h32, 32'h0,        32'hFFFF80FF, 0, 2, 0, 32'h0));
    vecs.push_back(mk(0, SZ_HALF, 0, 32'h32, 32'h0,        32'h000080FF, 0, 2, 0, 32'h0));
    vecs.push_back(mk(0, SZ_WORD, 1, 32'h30, 32'h0,        32'h80FF7F01, 0, 2, 0, 32'h0));
    vecs.push_back(mk(0, SZ_WORD, 0, 32'h12, 32'h0,        32'h0,        1, 1, 0, 32'h0));
    vecs.push_back(mk(0, SZ_HALF, 1, 32'h13, 32'h0,        32'h0,        1, 1, 0, 32'h0));
    vecs.push_back(mk(1, SZ_WORD, 0, 32'h11, 32'h55555555, 32'h0,        1, 1, 0, 32'h0));
    vecs.push_back(mk(0, SZ_ILL,  0, 32'h10, 32'h0,        32'h0,        1, 1, 0, 32'h0));
    vecs.push_back(mk(1, SZ_ILL,  0, 32'h10, 32'h66666666, 32'h0,        1, 1, 0, 32'h0));
    vecs.push_back(mk(1, SZ_HALF, 0, 32'h12, 32'h5555BEEF, 32'h0,        0, 3, 1, 32'hBEEF12EF));
    vecs.push_back(mk(0, SZ_HALF, 0, 32'h12, 32'h0,        32'h0000BEEF, 0, 2, 0, 32'h0));
    vecs.push_back(mk(0, SZ_HALF, 1, 32'h12, 32'h0,        32'hFFFFBEEF, 0, 2, 0, 32'h0));
    vecs.push_back(mk(1, SZ_BYTE, 0, 32'h13, 32'h00000077, 32'h0,        0, 3, 1, 32'h77EF12EF));
    vecs.push_back(mk(0, SZ_BYTE, 0, 32'h13, 32'h0,        32'h00000077, 0, 2, 0, 32'h0));
    vecs.push_back(mk(1, SZ_HALF, 0, 32'h10, 32'h00001234, 32'h0,        0, 3, 1, 32'h77EF1234));
    vecs.push_back(mk(1, SZ_BYTE, 0, 32'h10, 32'h0000009C, 32'h0,        0, 3, 1, 32'h77EF129C));
    vecs.push_back(mk(0, SZ_WORD, 0, 32'h10, 32'h0,        32'h77EF129C, 0, 2, 0, 32'h0));
    vecs.push_back(mk(0, SZ_BYTE, 1, 32'h10, 32'h0,        32'hFFFFFF9C, 0, 2, 0, 32'h0));
    vecs.push_back(mk(1, SZ_WORD, 0, 32'h24, 32'h11223344, 32'h0,        0, 2, 1, 32'h11223344));

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    reset = 1'b0;
    mem_init = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    mon_en = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      do_req(vecs[i], 1'b0);
      drain();
    end

    // Back-to-back with req_valid held high across both requests.
    do_req(mk(1, SZ_WORD, 0, 32'h20, 32'hCAFEF00D, 32'h0, 0, 2, 1, 32'hCAFEF00D), 1'b1);
    do_req(mk(0, SZ_WORD, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0, 2, 0, 32'h0), 1'b0);
    drain();

    // Reset during the STORE cycle of a byte store: no write, no response.
    @(negedge clk);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_signed = 1'b0;
    req_addr = 32'h25; req_wdata = 32'h000000AA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("abort_mem_we", {31'b0, mem_we}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_no_resp", {31'b0, resp_valid}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_rst", {31'b0, req_ready}, 32'd1);
    chk("abort_mem_word", tb_mem[9], 32'h11223344);
    do_req(mk(0, SZ_WORD, 0, 32'h24, 32'h0, 32'h11223344, 0, 2, 0, 32'h0), 1'b0);
    drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
